// File: rtl/fifo_stream_out.sv
// Read-side adapter for the synchronous FIFO: turns pop/registered-q into a
// valid/ready stream, absorbing the one-cycle read latency in a small buffer.
module fifo_stream_out #(
  parameter int WIDTH       = 8,
  parameter int BUF_DEPTH   = 2,
  parameter int LEVEL_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_q,
  output logic                   fifo_pop,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEVEL_WIDTH-1:0] level
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W-1:0]       LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [LEVEL_WIDTH:0]   DEPTH_EXT = (LEVEL_WIDTH + 1)'(BUF_DEPTH);

  logic [WIDTH-1:0]       buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [LEVEL_WIDTH-1:0] buf_count;
  logic                   inflight;
  logic                   take;
  logic [LEVEL_WIDTH:0]   committed;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (buf_count != '0);
  assign out_data  = buf_mem[rd_ptr];
  assign level     = buf_count;
  assign take      = out_valid & out_ready;

  // Slots already spoken for once this cycle's take leaves; the extra bit keeps
  // the sum from wrapping. out_ready reaches fifo_pop combinationally here.
  assign committed = {1'b0, buf_count} + (LEVEL_WIDTH + 1)'(inflight)
                   - (LEVEL_WIDTH + 1)'(take);
  assign fifo_pop  = !rst && !fifo_empty && (committed < DEPTH_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      buf_count <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_pop;
      if (take)
        rd_ptr <= next_ptr(rd_ptr);
      if (inflight)
        wr_ptr <= next_ptr(wr_ptr);
      case ({inflight, take})
        2'b10:   buf_count <= buf_count + LEVEL_WIDTH'(1);
        2'b01:   buf_count <= buf_count - LEVEL_WIDTH'(1);
        default: buf_count <= buf_count;
      endcase
    end
  end

  // Storage needs no reset; a word returning during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && inflight)
      buf_mem[wr_ptr] <= fifo_q;
  end

endmodule
